// File: rtl/dbg_frame_pkg.sv
// Shared types and helpers for the debug frame scheduler: FSM states, default header, byte XOR.
package dbg_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CKSUM = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
   localparam int         MAX_NBYTES   = 16;

   // Callers zero-extend narrower words; zero bytes do not change the XOR.
   function automatic logic [7:0] xor_reduce_bytes(input logic [MAX_NBYTES*8-1:0] d);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < MAX_NBYTES; i++) begin
         acc = acc ^ d[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/dbg_frame_sched_trig_sync.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous level input.
// Pulse is registered: one clk wide, three clk edges after the input rises.
module trig_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;
   logic pulse_q, pulse_d;

   always_comb begin
      s1_d    = async_in;
      s2_d    = s1_q;
      s3_d    = s2_q;
      pulse_d = s2_q & ~s3_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/dbg_frame_sched.sv
// Frames a captured debug word (header, data MSB-first, optional XOR checksum when
// DBG_FRAME_CKSUM_EN is defined) onto a valid/ready byte stream; 4 clk edges trig->tx_valid.
// Back-pressure: tx_data/tx_valid hold while tx_ready=0; one trigger queued, further ones counted as drops.
module dbg_frame_sched
   import dbg_frame_pkg::*;
#(
   parameter int          NBYTES     = 8,
   parameter logic [7:0]  HDR_BYTE   = DEF_HDR_BYTE,
   parameter int          GAP_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                trig,
   input  logic [NBYTES*8-1:0] snap_data,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic [7:0]          drop_cnt
);

   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NBYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam state_t POST_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

`ifdef DBG_FRAME_CKSUM_EN
   localparam state_t AFTER_DATA = ST_CKSUM;
   logic [7:0] cksum_q, cksum_d;
`else
   localparam state_t AFTER_DATA = POST_FRAME;
`endif

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                pending_q, pending_d;
   logic [7:0]          drop_q, drop_d;
   logic [NBYTES*8-1:0] shadow_q, shadow_d;
   logic                trig_pulse;
   logic                xfer;

   trig_sync u_trig_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (trig),
      .pulse    (trig_pulse)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      pending_d = pending_q;
      drop_d    = drop_q;
      shadow_d  = shadow_q;
`ifdef DBG_FRAME_CKSUM_EN
      cksum_d   = cksum_q;
`endif
      tx_valid  = 1'b0;
      tx_data   = 8'h00;

      case (state_q)
         ST_HDR: begin
            tx_valid = 1'b1;
            tx_data  = HDR_BYTE;
         end
         ST_DATA: begin
            tx_valid = 1'b1;
            tx_data  = shadow_q[{idx_q, 3'b000} +: 8];
         end
`ifdef DBG_FRAME_CKSUM_EN
         ST_CKSUM: begin
            tx_valid = 1'b1;
            tx_data  = cksum_q;
         end
`endif
         default: ;
      endcase
      xfer = tx_valid & tx_ready;

      // A pending request is served first; a simultaneous new pulse re-arms pending.
      if (state_q == ST_IDLE) begin
         if (pending_q || trig_pulse) begin
            shadow_d  = snap_data;
`ifdef DBG_FRAME_CKSUM_EN
            cksum_d   = HDR_BYTE ^ xor_reduce_bytes((MAX_NBYTES*8)'(snap_data));
`endif
            pending_d = pending_q & trig_pulse;
            state_d   = ST_HDR;
         end
      end else if (trig_pulse) begin
         if (!pending_q) begin
            pending_d = 1'b1;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end

      case (state_q)
         ST_HDR: begin
            if (xfer) begin
               state_d = ST_DATA;
               idx_d   = IDX_TOP;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               if (idx_q == '0) begin
                  state_d = AFTER_DATA;
                  gap_d   = '0;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
`ifdef DBG_FRAME_CKSUM_EN
         ST_CKSUM: begin
            if (xfer) begin
               state_d = POST_FRAME;
               gap_d   = '0;
            end
         end
`endif
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         gap_q     <= '0;
         pending_q <= 1'b0;
         drop_q    <= 8'h00;
         shadow_q  <= '0;
`ifdef DBG_FRAME_CKSUM_EN
         cksum_q   <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         shadow_q  <= shadow_d;
`ifdef DBG_FRAME_CKSUM_EN
         cksum_q   <= cksum_d;
`endif
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_dbg_frame_sched.sv
// Directed bench for dbg_frame_sched: per-cycle vector tables plus hand-written trigger sequences.
module tb_dbg_frame_sched;

   logic        clk = 1'b0;
   logic        rst_n, trig, tx_ready, tx_valid, busy;
   logic [63:0] snap;
   logic [7:0]  tx_data, drop_cnt;

   logic        trig0, tx_ready0, tx_valid0, busy0;
   logic [15:0] snap0;
   logic [7:0]  tx_data0, drop_cnt0;

   always #5 clk = ~clk;

   dbg_frame_sched #(.NBYTES(8), .HDR_BYTE(8'hA5), .GAP_CYCLES(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .snap_data(snap),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   dbg_frame_sched #(.NBYTES(2), .HDR_BYTE(8'hA5), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .trig(trig0), .snap_data(snap0),
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .busy(busy0), .drop_cnt(drop_cnt0)
   );

   typedef struct {
      logic       rdy;
      logic       v;
      logic [7:0] d;
      logic       b;
   } vec_t;

   vec_t        tbl[$];
   vec_t        tbl0[$];
   logic [7:0]  mon_q[$];
   logic [7:0]  exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) mon_q.push_back(tx_data);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      repeat (3) step();
      trig = 1'b0;
      repeat (3) step();
   endtask

   function automatic void exp_frame(input logic [63:0] s);
      logic [7:0] ck;
      logic [7:0] b;
      ck = 8'hA5;
      exp_q.push_back(8'hA5);
      for (int i = 7; i >= 0; i--) begin
         b  = s[i*8 +: 8];
         ck = ck ^ b;
         exp_q.push_back(b);
      end
`ifdef DBG_FRAME_CKSUM_EN
      exp_q.push_back(ck);
`endif
   endfunction

   function automatic vec_t mk(input logic rdy, input logic v, input logic [7:0] d, input logic b);
      vec_t r;
      r.rdy = rdy; r.v = v; r.d = d; r.b = b;
      return r;
   endfunction

   task automatic cmp_stream(input string name);
      chk({name, " length"}, mon_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         chk($sformatf("%s byte%0d", name, i), mon_q[i], exp_q[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout: got no finish, expected finish before 1 ms");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] sa, sc, sd, se;
      int k;
      rst_n = 1'b0; trig = 1'b0; tx_ready = 1'b0; snap = '0;
      trig0 = 1'b0; tx_ready0 = 1'b0; snap0 = '0;

      // Frame with a 5-cycle stall on byte 45, then the 16-cycle gap.
      tbl.push_back(mk(1, 1, 8'hA5, 1));
      tbl.push_back(mk(1, 1, 8'h01, 1));
      tbl.push_back(mk(1, 1, 8'h23, 1));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 8'h45, 1));
      tbl.push_back(mk(1, 1, 8'h45, 1));
      tbl.push_back(mk(1, 1, 8'h67, 1));
      tbl.push_back(mk(1, 1, 8'h89, 1));
      tbl.push_back(mk(1, 1, 8'hAB, 1));
      tbl.push_back(mk(1, 1, 8'hCD, 1));
      tbl.push_back(mk(1, 1, 8'hEF, 1));
`ifdef DBG_FRAME_CKSUM_EN
      tbl.push_back(mk(1, 1, 8'hA5, 1));
`endif
      for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 8'h00, 1));
      tbl.push_back(mk(1, 0, 8'h00, 0));

      // GAP_CYCLES=0, NBYTES=2, second request pending: one idle cycle between frames.
      for (int f = 0; f < 2; f++) begin
         tbl0.push_back(mk(1, 1, 8'hA5, 1));
         tbl0.push_back(mk(1, 1, 8'hBE, 1));
         tbl0.push_back(mk(1, 1, 8'hEF, 1));
`ifdef DBG_FRAME_CKSUM_EN
         tbl0.push_back(mk(1, 1, 8'hF4, 1));
`endif
         tbl0.push_back(mk(1, 0, 8'h00, 0));
      end
      tbl0.push_back(mk(1, 0, 8'h00, 0));

      repeat (3) step();
      chk("reset tx_valid", tx_valid, 1'b0);
      chk("reset tx_data", tx_data, 8'h00);
      chk("reset busy", busy, 1'b0);
      chk("reset drop_cnt", drop_cnt, 8'h00);
      rst_n = 1'b1;
      repeat (2) step();

      // Single trigger: latency, then the vector table.
      mon_q.delete(); exp_q.delete();
      snap = 64'h0123_4567_89AB_CDEF;
      trig = 1'b1;
      k = 0;
      for (int i = 1; i <= 8; i++) begin
         step();
         k = i;
         if (tx_valid) break;
      end
      chk("trig->tx_valid edges", k, 4);
      trig = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         tx_ready = tbl[i].rdy;
         chk($sformatf("t1 row%0d tx_valid", i), tx_valid, tbl[i].v);
         if (tbl[i].v) chk($sformatf("t1 row%0d tx_data", i), tx_data, tbl[i].d);
         chk($sformatf("t1 row%0d busy", i), busy, tbl[i].b);
         step();
      end
      exp_frame(64'h0123_4567_89AB_CDEF);
      cmp_stream("t1 stream");

      // Three triggers 20 cycles apart while stalled on the header.
      mon_q.delete(); exp_q.delete();
      sa = 64'h1111_2222_3333_4444;
      sc = 64'h5A5A_0F0F_C3C3_9696;
      tx_ready = 1'b0; snap = sa; trig = 1'b1;
      for (int i = 0; i < 20 && !tx_valid; i++) step();
      chk("t3 first frame started", tx_valid, 1'b1);
      trig = 1'b0;
      repeat (16) step();
      snap = 64'hBBBB_BBBB_BBBB_BBBB;
      trig = 1'b1; repeat (3) step(); trig = 1'b0; repeat (4) step();
      chk("t3 pending after 2nd", u_dut.pending_q, 1'b1);
      chk("t3 drop after 2nd", drop_cnt, 8'd0);
      repeat (13) step();
      trig = 1'b1; repeat (3) step(); trig = 1'b0; repeat (4) step();
      chk("t3 pending after 3rd", u_dut.pending_q, 1'b1);
      chk("t3 drop after 3rd", drop_cnt, 8'd1);
      chk("t3 stalled tx_data", tx_data, 8'hA5);
      snap = sc;
      tx_ready = 1'b1;
      repeat (80) step();
      chk("t3 idle after two frames", busy, 1'b0);
      exp_frame(sa);
      exp_frame(sc);
      cmp_stream("t3 stream");

      // Drop counter saturation while stalled with a request pending.
      tx_ready = 1'b0;
      pulse_trig();
      pulse_trig();
      chk("t4 pending set", u_dut.pending_q, 1'b1);
      chk("t4 drop start", drop_cnt, 8'd1);
      repeat (100) pulse_trig();
      chk("t4 drop after 100", drop_cnt, 8'd101);
      repeat (200) pulse_trig();
      chk("t4 drop saturated", drop_cnt, 8'hFF);
      repeat (5) pulse_trig();
      chk("t4 drop stays", drop_cnt, 8'hFF);
      #2 rst_n = 1'b0;
      #1;
      chk("t4 reset tx_valid", tx_valid, 1'b0);
      chk("t4 reset busy", busy, 1'b0);
      chk("t4 reset drop_cnt", drop_cnt, 8'h00);
      step(); rst_n = 1'b1; step();

      // Reset after the third byte aborts the frame; next trigger gives a fresh one.
      mon_q.delete(); exp_q.delete();
      sd = 64'hDEAD_BEEF_CAFE_F00D;
      se = 64'h0F1E_2D3C_4B5A_6978;
      tx_ready = 1'b1; snap = sd;
      pulse_trig();
      for (int i = 0; i < 40 && mon_q.size() < 3; i++) step();
      chk("t5 three bytes sent", mon_q.size(), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 mid-frame reset tx_valid", tx_valid, 1'b0);
      chk("t5 mid-frame reset busy", busy, 1'b0);
      #2;
      step(); rst_n = 1'b1; step();
      mon_q.delete();
      snap = se;
      pulse_trig();
      repeat (40) step();
      exp_frame(se);
      cmp_stream("t5 fresh stream");

      // Zero gap with a pending request on the second instance.
      snap0 = 16'hBEEF; tx_ready0 = 1'b0; trig0 = 1'b1;
      for (int i = 0; i < 10 && !tx_valid0; i++) step();
      chk("t6 first frame started", tx_valid0, 1'b1);
      trig0 = 1'b0; repeat (3) step();
      trig0 = 1'b1; repeat (3) step();
      trig0 = 1'b0; repeat (3) step();
      chk("t6 pending", u_dut0.pending_q, 1'b1);
      for (int i = 0; i < tbl0.size(); i++) begin
         tx_ready0 = tbl0[i].rdy;
         chk($sformatf("t6 row%0d tx_valid", i), tx_valid0, tbl0[i].v);
         if (tbl0[i].v) chk($sformatf("t6 row%0d tx_data", i), tx_data0, tbl0[i].d);
         chk($sformatf("t6 row%0d busy", i), busy0, tbl0[i].b);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dbg_frame_sched.md
Name: dbg_frame_sched

Overview:
- Schedules debug snapshots of the CPU onto the board UART transmitter.
- On each rising edge of a trigger (the CPU step clock), it captures an NBYTES-wide debug word and emits a framed byte stream: header, then data MSB-first, then an optional checksum.
- Sits between the onboard debug bus (clks/pclow/memwrite/addr/check) and the byte-level UART TX. It owns the valid/ready handshake and back-pressure accounting.

Parameters:
- NBYTES, 8, number of snapshot bytes per frame (2..16).
- HDR_BYTE, 8'hA5, frame header byte.
- GAP_CYCLES, 16, idle clk cycles enforced after each frame (0 = none).

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  reset; asynchronous, active-low.
- trig  in  1  snapshot request, asynchronous level; a rising edge requests one frame.
- snap_data  in  NBYTES*8  debug word; sampled at capture.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte this cycle.
- busy  out  1  a frame is in progress (any state other than IDLE).
- drop_cnt  out  8  count of lost triggers, saturating.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, pending=0, synchronizer flops 0.
- Trigger path:
  - trig passes through a 2-flop synchronizer, then an edge register.
  - trig_pulse = s2 & ~s3, one cycle wide.
- Capture:
  - trig_pulse in IDLE: latch snap_data into shadow register, go to HDR.
  - tx_valid rises the next cycle. Latency is 4 clk edges from trig high to tx_valid=1.
- Transfer rule:
  - A byte moves only on tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid are held stable.
  - tx_valid never drops without a transfer.
- FSM states and transitions:
  - IDLE: tx_valid=0. Leave on trig_pulse or pending.
  - HDR: tx_data=HDR_BYTE. On transfer -> DATA, byte index idx=NBYTES-1.
  - DATA: tx_data=shadow[idx*8+:8]. On transfer, if idx==0 -> CKSUM (feature on) or GAP, else idx--.
  - CKSUM: see Optional Feature.
  - GAP: tx_valid=0. Count GAP_CYCLES cycles, then -> IDLE.
    - GAP_CYCLES=0: go from the last byte directly to IDLE.
- Triggers while busy:
  - First trig_pulse while busy sets pending=1 (depth 1).
  - A trig_pulse while pending=1 increments drop_cnt, saturating at 8'hFF.
  - On IDLE with pending=1: capture snap_data at that cycle, clear pending, go to HDR.
    - The snapshot is taken at service time, not trigger time.
  - trig_pulse arriving in the same cycle as pending is serviced: counts as a new pending (pending stays 1).
- Reset mid-frame: abort immediately; the partial frame is not completed. The downstream sees tx_valid drop asynchronously.
- Wrap: idx is $clog2(NBYTES) bits and never wraps below 0; drop_cnt never wraps.

Optional Feature:
- Macro: DBG_FRAME_CKSUM_EN.
- Defined:
  - CKSUM state after DATA emits XOR of HDR_BYTE and all NBYTES data bytes.
  - Checksum is accumulated from the shadow register at capture time.
  - Frame length = NBYTES+2.
- Undefined:
  - CKSUM state and accumulator are absent; DATA goes directly to GAP.
  - Frame length = NBYTES+1.

Decomposition:
- Package dbg_frame_pkg:
  - state_t enum (IDLE, HDR, DATA, CKSUM, GAP).
  - default HDR_BYTE constant.
  - function xor_reduce_bytes.
- Sub-module trig_sync:
  - 2-flop synchronizer plus rising-edge detect, async active-low reset.
  - Reusable for the other asynchronous board inputs (push buttons).

Test Plan:
- Reset release, NBYTES=8, tx_ready=1, snap_data=64'h0123_4567_89AB_CDEF, single trig pulse.
  - Without CKSUM: bytes A5,01,23,45,67,89,AB,CD,EF.
  - With CKSUM: the same plus checksum byte 8'hA5.
  - busy=0 after GAP_CYCLES=16 idle cycles.
- Back-pressure: tx_ready held 0 for 5 cycles during the byte 45.
  - tx_data=45 and tx_valid=1 remain stable all 5 cycles.
  - No byte is skipped or duplicated.
- Three trig pulses 20 cycles apart while the first frame is stalled (tx_ready=0).
  - pending=1 after the second, drop_cnt=1 after the third.
  - Exactly two frames emitted.
  - The second frame carries the snap_data present at its IDLE service cycle.
- 300 extra triggers while busy with pending set: drop_cnt saturates at 8'hFF and stays.
- rst_n pulsed low after the 3rd byte of a frame.
  - tx_valid=0 and busy=0 immediately.
  - Next trig yields a complete fresh frame starting with A5.
- GAP_CYCLES=0 with trig pending: the header of the second frame is presented 1 cycle after the last byte of the first frame is accepted.
